math_divider_scheduler: RTL and testbench
=========================================

MATH_DIVIDER_SCHEDULER -- requirements
Module: math_divider_scheduler

Interface
REQ-001 Parameter: NUM_REQ, 4, number of requesters (legal range 2..16).
REQ-002 Parameter: DATA_WIDTH, 16, operand and result width.
REQ-003 Port: i_clk  input  1  the single clock; all logic is rising-edge.
REQ-004 Port: i_rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: i_req_valid  input  NUM_REQ  per-requester request pending.
REQ-006 Port: i_req_dividend / i_req_divisor  input  NUM_REQ x DATA_WIDTH each  per-requester operands, held stable while valid.
REQ-007 Port: o_req_ready  output  NUM_REQ  one-hot accept pulse to the granted requester.
REQ-008 Port: o_div_start  output  1  one-cycle start pulse to the shared divider.
REQ-009 Port: o_div_dividend / o_div_divisor  output  DATA_WIDTH each  registered operands to the divider.
REQ-010 Port: i_div_done / i_div_valid / i_div_dbz  input  1 each  divider completion, result-valid and divide-by-zero flags.
REQ-011 Port: i_div_quotient / i_div_remainder  input  DATA_WIDTH each  divider results.
REQ-012 Port: o_rsp_valid / o_rsp_dbz  output  1 each  response valid; response carries divide-by-zero.
REQ-013 Port: o_rsp_id  output  $clog2(NUM_REQ)  index of the requester that owns the response.
REQ-014 Port: o_rsp_quotient / o_rsp_remainder  output  DATA_WIDTH each  response results.
REQ-015 Port: i_rsp_ready  input  1  response accepted when high with o_rsp_valid.
REQ-016 Port: o_busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: if any i_req_valid bit is set, grant one round-robin, pulse o_req_ready[grant], latch operands and id, and go to ISSUE.
REQ-019 ISSUE: pulse o_div_start for exactly one cycle with latched operands, then go to WAIT (grant-to-start = 1 cycle).
REQ-020 WAIT: on i_div_done, capture quotient, remainder and dbz into the response registers, then go to RESP; i_div_done is ignored in every other state.
REQ-021 RESP: o_rsp_valid is held with all response fields stable until i_rsp_ready; on the accepting cycle go to IDLE; no grant occurs in that same cycle.
REQ-022 Round-robin: search starts at last_grant+1 modulo NUM_REQ; the pointer updates only on a grant; after reset the pointer makes requester 0 highest priority.
REQ-023 Only one operation is outstanding; o_div_start never asserts outside ISSUE.
REQ-024 Divide-by-zero: the response has o_rsp_dbz=1 and the quotient/remainder fields forced to 0, independent of divider data.
REQ-025 A requester that drops i_req_valid before grant is not served; the block does not check operand stability after grant.

Reset
REQ-026 Reset applied, including mid-operation: state=IDLE, rr pointer=NUM_REQ-1, and all outputs are 0.
REQ-027 After reset release, a late i_div_done from an aborted operation is discarded because it arrives outside WAIT.

Configuration
REQ-028 Macro: MATH_DIVIDER_SCHEDULER_STATS_EN.
- Defined: the block adds outputs o_stat_ops (32 bit, +1 per accepted response) and o_stat_dbz (32 bit, +1 per dbz response).
- Both counters wrap and reset to 0.
REQ-029 Macro undefined: the stat ports still exist, are tied to 0, and no counter flops are inferred.

Structure
REQ-030 Package math_divider_sched_pkg holds the FSM state enum and a response struct (id, dbz, quotient, remainder).
REQ-031 Sub-module arbiter_round_robin_simple (NUM_REQ param; request vector, enable, one-hot grant, grant index) implements REQ-022.

Verification (DATA_WIDTH=16, NUM_REQ=4; divider model: done DATA_WIDTH+1 cycles after start, or 1 cycle for dbz)
REQ-032 Requester 1 sends 100/7 -> o_req_ready=0010; start 1 cycle later; response id=1, q=14, r=2, dbz=0.
REQ-033 All four valid continuously -> grant order 0,1,2,3,0; exactly one start per response.
REQ-034 Requester 2 sends 5/0 -> response id=2, dbz=1, q=0, r=0; o_stat_dbz=1 with the macro defined.
REQ-035 i_rsp_ready held low 10 cycles in RESP -> response fields stable, no o_req_ready, no o_div_start.
REQ-036 Reset asserted in WAIT, then i_div_done arrives after release -> all outputs stay 0; the next request 9/3 returns q=3, r=0.

Source files
------------

// File: rtl/math_divider_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// math_divider_sched_pkg
// Shared types for the divider scheduler: the FSM state encoding, the
// response record held while a result waits for the requester, and the
// round-robin index helper used by the arbiter.
// The response record is sized for the largest supported configuration
// (16 requesters, 64-bit data). Narrower builds use only the low bits.
// -----------------------------------------------------------------------------
package math_divider_sched_pkg;

  localparam int RSP_ID_W_MAX   = 4;
  localparam int RSP_DATA_W_MAX = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [RSP_ID_W_MAX-1:0]   id;
    logic                      dbz;
    logic [RSP_DATA_W_MAX-1:0] quotient;
    logic [RSP_DATA_W_MAX-1:0] remainder;
  } sched_rsp_t;

  // Index that lies 'offs' positions after 'base' in a ring of 'n' slots.
  function automatic int unsigned rr_next(input int unsigned base,
                                          input int unsigned offs,
                                          input int unsigned n);
    return (base + offs) % n;
  endfunction

endpackage

// File: rtl/math_divider_scheduler_if.sv
// -----------------------------------------------------------------------------
// math_divider_scheduler_if
// Requester-side bus of the divider scheduler: per-requester request
// valid/operands, the one-hot accept pulse, and the response channel.
// Signal prefixes are seen from the scheduler (i_ = into it, o_ = out of it).
//   master : requester side (drives i_*, samples o_*)
//   slave  : scheduler side (samples i_*, drives o_*)
// -----------------------------------------------------------------------------
interface math_divider_scheduler_if
  import math_divider_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                 i_req_valid;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] i_req_dividend;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] i_req_divisor;
  logic [NUM_REQ-1:0]                 o_req_ready;
  logic                               o_rsp_valid;
  logic                               o_rsp_dbz;
  logic [ID_W-1:0]                    o_rsp_id;
  logic [DATA_WIDTH-1:0]              o_rsp_quotient;
  logic [DATA_WIDTH-1:0]              o_rsp_remainder;
  logic                               i_rsp_ready;

  modport master (
    output i_req_valid, i_req_dividend, i_req_divisor, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_dbz, o_rsp_id,
           o_rsp_quotient, o_rsp_remainder
  );

  modport slave (
    input  i_req_valid, i_req_dividend, i_req_divisor, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_dbz, o_rsp_id,
           o_rsp_quotient, o_rsp_remainder
  );

endinterface

// File: rtl/math_divider_scheduler_arbiter.sv
// -----------------------------------------------------------------------------
// arbiter_round_robin_simple
// Round-robin arbiter. The search begins one slot after the last winner and
// wraps modulo NUM_REQ; the pointer moves only when a grant is issued. After
// reset the pointer sits on NUM_REQ-1 so requester 0 is searched first.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_req         : request vector
//   i_en          : grant enable (no grant and no pointer move when low)
//   o_grant       : one-hot grant (zero when disabled or no request)
//   o_grant_idx   : index of the winning requester
// -----------------------------------------------------------------------------
module arbiter_round_robin_simple
  import math_divider_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx
);

  logic [ID_W-1:0] r_last;
  logic            w_found;
  logic [ID_W-1:0] w_idx;
  logic [ID_W-1:0] w_cand;

  // Walk the ring starting just after the last winner; first hit wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = ID_W'(rr_next({{(32-ID_W){1'b0}}, r_last}, i, NUM_REQ));
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (i_en && w_found) o_grant[w_idx] = 1'b1;
  end

  assign o_grant_idx = w_idx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                r_last <= ID_W'(NUM_REQ - 1);
    else if (i_en && w_found) r_last <= w_idx;
  end

endmodule

// File: rtl/math_divider_scheduler.sv
// -----------------------------------------------------------------------------
// math_divider_scheduler
// Shares one multi-cycle divider among NUM_REQ requesters. One operation is
// outstanding at a time: IDLE grants round-robin and latches the operands,
// ISSUE pulses the divider start, WAIT captures the divider result, RESP
// holds the response until the requester accepts it.
// Ports:
//   i_clk, i_rst       : clock, asynchronous active-high reset
//   bus (slave)        : request valid/operands, one-hot accept, response
//   o_div_start        : one-cycle divider start (only in ISSUE)
//   o_div_dividend/o_div_divisor : latched operands to the divider
//   i_div_done/i_div_valid/i_div_dbz/i_div_quotient/i_div_remainder
//                      : divider completion and results (used only in WAIT)
//   o_busy             : high whenever the FSM is not IDLE
//   o_stat_ops/o_stat_dbz : accepted-response and dbz-response counters
// Build option: define MATH_DIVIDER_SCHEDULER_STATS_EN to implement the
// counters; otherwise the stat ports are tied to zero.
// -----------------------------------------------------------------------------
module math_divider_scheduler
  import math_divider_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  math_divider_scheduler_if.slave bus,
  output logic                  o_div_start,
  output logic [DATA_WIDTH-1:0] o_div_dividend,
  output logic [DATA_WIDTH-1:0] o_div_divisor,
  input  logic                  i_div_done,
  input  logic                  i_div_valid,
  input  logic                  i_div_dbz,
  input  logic [DATA_WIDTH-1:0] i_div_quotient,
  input  logic [DATA_WIDTH-1:0] i_div_remainder,
  output logic                  o_busy,
  output logic [31:0]           o_stat_ops,
  output logic [31:0]           o_stat_dbz
);

  localparam int ID_W = $clog2(NUM_REQ);

  sched_state_e          r_state;
  sched_state_e          w_state_nxt;
  logic                  w_arb_en;
  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_W-1:0]       w_grant_idx;
  logic                  w_capture;
  logic                  w_data_ok;
  logic [DATA_WIDTH-1:0] r_op_dividend;
  logic [DATA_WIDTH-1:0] r_op_divisor;
  logic [ID_W-1:0]       r_op_id;
  sched_rsp_t            r_rsp;
  logic                  w_unused_rsp;

  // Arbitration only in IDLE; also held off while reset is asserted so the
  // accept pulse stays low during reset even with requests pending.
  assign w_arb_en = (r_state == S_IDLE) && !i_rst;

  arbiter_round_robin_simple #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (bus.i_req_valid),
    .i_en        (w_arb_en),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign bus.o_req_ready = w_grant;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    o_div_start     = 1'b0;
    o_busy          = 1'b1;
    bus.o_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (|w_grant) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        o_div_start = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_div_done) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        bus.o_rsp_valid = 1'b1;
        if (bus.i_rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A done outside WAIT (e.g. from an operation aborted by reset) is dropped.
  assign w_capture = (r_state == S_WAIT) && i_div_done;
  // Result data is passed through only for a real quotient; a divide-by-zero
  // (or a completion without valid data) reports zeros.
  assign w_data_ok = i_div_valid && !i_div_dbz;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op_dividend <= '0;
      r_op_divisor  <= '0;
      r_op_id       <= '0;
      r_rsp         <= '0;
    end else begin
      if (|w_grant) begin
        r_op_dividend <= bus.i_req_dividend[w_grant_idx];
        r_op_divisor  <= bus.i_req_divisor[w_grant_idx];
        r_op_id       <= w_grant_idx;
      end
      if (w_capture) begin
        r_rsp.id        <= RSP_ID_W_MAX'(r_op_id);
        r_rsp.dbz       <= i_div_dbz;
        r_rsp.quotient  <= w_data_ok ? RSP_DATA_W_MAX'(i_div_quotient)  : '0;
        r_rsp.remainder <= w_data_ok ? RSP_DATA_W_MAX'(i_div_remainder) : '0;
      end
    end
  end

  assign o_div_dividend      = r_op_dividend;
  assign o_div_divisor       = r_op_divisor;
  assign bus.o_rsp_id        = r_rsp.id[ID_W-1:0];
  assign bus.o_rsp_dbz       = r_rsp.dbz;
  assign bus.o_rsp_quotient  = r_rsp.quotient[DATA_WIDTH-1:0];
  assign bus.o_rsp_remainder = r_rsp.remainder[DATA_WIDTH-1:0];

  // The record is sized for the widest build; its padding bits are not read.
  assign w_unused_rsp = ^r_rsp;

`ifdef MATH_DIVIDER_SCHEDULER_STATS_EN
  logic        w_rsp_accept;
  logic [31:0] r_stat_ops;
  logic [31:0] r_stat_dbz;

  assign w_rsp_accept = (r_state == S_RESP) && bus.i_rsp_ready;

  // Free-running wrap-around counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stat_ops <= '0;
      r_stat_dbz <= '0;
    end else if (w_rsp_accept) begin
      r_stat_ops <= r_stat_ops + 32'd1;
      if (r_rsp.dbz) r_stat_dbz <= r_stat_dbz + 32'd1;
    end
  end

  assign o_stat_ops = r_stat_ops;
  assign o_stat_dbz = r_stat_dbz;
`else
  assign o_stat_ops = '0;
  assign o_stat_dbz = '0;
`endif

endmodule

// File: tb/tb_math_divider_scheduler.sv
// -----------------------------------------------------------------------------
// tb_math_divider_scheduler
// Directed bench for math_divider_scheduler (NUM_REQ=4, DATA_WIDTH=16) with a
// behavioural divider: done 17 cycles after start, or 1 cycle for a zero
// divisor (dbz=1, valid=0, junk data on the result buses).
// -----------------------------------------------------------------------------
module tb_math_divider_scheduler;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 16;

  logic        clk;
  logic        rst;
  logic        div_start;
  logic [15:0] div_dividend;
  logic [15:0] div_divisor;
  logic        div_done;
  logic        div_valid;
  logic        div_dbz;
  logic [15:0] div_q;
  logic [15:0] div_r;
  logic        busy;
  logic [31:0] stat_ops;
  logic [31:0] stat_dbz;

  int errors = 0;
  int checks = 0;
  int done_count = 0;

  math_divider_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  math_divider_scheduler #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .bus             (bus),
    .o_div_start     (div_start),
    .o_div_dividend  (div_dividend),
    .o_div_divisor   (div_divisor),
    .i_div_done      (div_done),
    .i_div_valid     (div_valid),
    .i_div_dbz       (div_dbz),
    .i_div_quotient  (div_q),
    .i_div_remainder (div_r),
    .o_busy          (busy),
    .o_stat_ops      (stat_ops),
    .o_stat_dbz      (stat_dbz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Divider model, updated 1 time unit after each rising edge.
  initial begin
    int          dcnt;
    logic [15:0] m_a;
    logic [15:0] m_b;
    dcnt = 0; m_a = '0; m_b = '0;
    div_done = 1'b0; div_valid = 1'b0; div_dbz = 1'b0; div_q = '0; div_r = '0;
    forever begin
      @(posedge clk);
      #1;
      div_done = 1'b0; div_valid = 1'b0; div_dbz = 1'b0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          div_done = 1'b1;
          done_count++;
          if (m_b == 16'd0) begin
            div_dbz = 1'b1; div_q = 16'hFFFF; div_r = 16'hFFFF;
          end else begin
            div_valid = 1'b1; div_q = m_a / m_b; div_r = m_a % m_b;
          end
        end
      end
      if (div_start) begin
        m_a  = div_dividend;
        m_b  = div_divisor;
        dcnt = (m_b == 16'd0) ? 1 : DATA_WIDTH + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Advance until a response is presented, counting divider starts seen.
  task automatic wait_rsp(input int limit, output int starts);
    bit got;
    starts = 0;
    got = 1'b0;
    for (int c = 0; c < limit && !got; c++) begin
      tick();
      if (div_start) starts++;
      if (bus.o_rsp_valid) got = 1'b1;
    end
    check("rsp_timeout", 64'(got), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int          starts;
    int          d0;
    bit          quiet;
    logic [15:0] exp_q [5];
    logic [15:0] exp_r [5];
    logic [1:0]  exp_id[5];

    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_q  = '{16'd25, 16'd17, 16'd13, 16'd10, 16'd25};
    exp_r  = '{16'd0,  16'd0,  16'd0,  16'd3,  16'd0};

    rst = 1'b1;
    bus.i_req_valid    = 4'b1111;
    bus.i_req_dividend = '0;
    bus.i_req_divisor  = '0;
    bus.i_rsp_ready    = 1'b0;
    tick();
    tick();
    // Reset state, with every requester asking
    check("rst_ready",    64'(bus.o_req_ready),    64'd0);
    check("rst_busy",     64'(busy),               64'd0);
    check("rst_start",    64'(div_start),          64'd0);
    check("rst_rsp_vld",  64'(bus.o_rsp_valid),    64'd0);
    check("rst_dividend", 64'(div_dividend),       64'd0);
    check("rst_rsp_q",    64'(bus.o_rsp_quotient), 64'd0);
    check("rst_stat_ops", 64'(stat_ops),           64'd0);
    bus.i_req_valid = 4'b0000;
    tick();
    rst = 1'b0;
    tick();

    // Requester 1: 100 / 7
    bus.i_req_dividend[1] = 16'd100;
    bus.i_req_divisor[1]  = 16'd7;
    bus.i_req_valid       = 4'b0010;
    #1;
    check("t1_ready", 64'(bus.o_req_ready), 64'h2);
    check("t1_idle",  64'(busy),            64'd0);
    tick();
    bus.i_req_valid = 4'b0000;
    check("t1_start",    64'(div_start),       64'd1);
    check("t1_op_a",     64'(div_dividend),    64'd100);
    check("t1_op_b",     64'(div_divisor),     64'd7);
    check("t1_ready_lo", 64'(bus.o_req_ready), 64'd0);
    wait_rsp(40, starts);
    check("t1_starts", 64'(starts),              64'd0);
    check("t1_id",     64'(bus.o_rsp_id),        64'd1);
    check("t1_q",      64'(bus.o_rsp_quotient),  64'd14);
    check("t1_r",      64'(bus.o_rsp_remainder), 64'd2);
    check("t1_dbz",    64'(bus.o_rsp_dbz),       64'd0);
    bus.i_rsp_ready = 1'b1;
    tick();
    bus.i_rsp_ready = 1'b0;
    check("t1_rsp_drop", 64'(bus.o_rsp_valid), 64'd0);
    check("t1_back_idle", 64'(busy),           64'd0);

    // All four requesting continuously from a fresh pointer
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.i_req_dividend[i] = 16'(50 + i);
      bus.i_req_divisor[i]  = 16'(i + 2);
    end
    bus.i_req_valid = 4'b1111;
    bus.i_rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      check($sformatf("rr%0d_ready", n), 64'(bus.o_req_ready), 64'(4'b0001 << exp_id[n]));
      wait_rsp(40, starts);
      check($sformatf("rr%0d_starts", n), 64'(starts),              64'd1);
      check($sformatf("rr%0d_id", n),     64'(bus.o_rsp_id),        64'(exp_id[n]));
      check($sformatf("rr%0d_q", n),      64'(bus.o_rsp_quotient),  64'(exp_q[n]));
      check($sformatf("rr%0d_r", n),      64'(bus.o_rsp_remainder), 64'(exp_r[n]));
      tick();
    end
    bus.i_req_valid = 4'b0000;
    bus.i_rsp_ready = 1'b0;
`ifdef MATH_DIVIDER_SCHEDULER_STATS_EN
    check("rr_stat_ops", 64'(stat_ops), 64'd5);
`else
    check("rr_stat_ops", 64'(stat_ops), 64'd0);
`endif
    tick();

    // Requester 2: 5 / 0, response then held for 10 cycles
    bus.i_req_dividend[2] = 16'd5;
    bus.i_req_divisor[2]  = 16'd0;
    bus.i_req_valid       = 4'b0100;
    #1;
    check("dbz_ready", 64'(bus.o_req_ready), 64'h4);
    wait_rsp(10, starts);
    bus.i_req_valid = 4'b0000;
    check("dbz_starts", 64'(starts),              64'd1);
    check("dbz_id",     64'(bus.o_rsp_id),        64'd2);
    check("dbz_flag",   64'(bus.o_rsp_dbz),       64'd1);
    check("dbz_q",      64'(bus.o_rsp_quotient),  64'd0);
    check("dbz_r",      64'(bus.o_rsp_remainder), 64'd0);
    bus.i_req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("hold%0d_vld", c),   64'(bus.o_rsp_valid),    64'd1);
      check($sformatf("hold%0d_id", c),    64'(bus.o_rsp_id),       64'd2);
      check($sformatf("hold%0d_dbz", c),   64'(bus.o_rsp_dbz),      64'd1);
      check($sformatf("hold%0d_q", c),     64'(bus.o_rsp_quotient), 64'd0);
      check($sformatf("hold%0d_ready", c), 64'(bus.o_req_ready),    64'd0);
      check($sformatf("hold%0d_start", c), 64'(div_start),          64'd0);
    end
    bus.i_rsp_ready = 1'b1;
    #1;
    check("acc_no_grant", 64'(bus.o_req_ready), 64'd0);
    tick();
    bus.i_rsp_ready = 1'b0;
    bus.i_req_valid = 4'b0000;
    check("acc_idle", 64'(busy), 64'd0);
`ifdef MATH_DIVIDER_SCHEDULER_STATS_EN
    check("stat_dbz", 64'(stat_dbz), 64'd1);
    check("stat_ops", 64'(stat_ops), 64'd6);
`else
    check("stat_dbz", 64'(stat_dbz), 64'd0);
    check("stat_ops", 64'(stat_ops), 64'd0);
`endif
    tick();

    // Requester 0: 77 / 5, aborted by reset while in WAIT
    bus.i_req_dividend[0] = 16'd77;
    bus.i_req_divisor[0]  = 16'd5;
    bus.i_req_valid       = 4'b0001;
    #1;
    check("ab_ready", 64'(bus.o_req_ready), 64'h1);
    tick();
    bus.i_req_valid = 4'b0000;
    tick();
    tick();
    check("ab_wait_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("ab_rst_busy",  64'(busy),         64'd0);
    check("ab_rst_opa",   64'(div_dividend), 64'd0);
    check("ab_rst_opb",   64'(div_divisor),  64'd0);
    check("ab_rst_stat",  64'(stat_ops),     64'd0);
    tick();
    tick();
    rst = 1'b0;
    d0 = done_count;
    quiet = 1'b1;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (busy || bus.o_rsp_valid || div_start || bus.o_rsp_dbz ||
          (bus.o_rsp_quotient != 16'd0) || (div_dividend != 16'd0) ||
          (bus.o_req_ready != 4'd0))
        quiet = 1'b0;
    end
    check("ab_late_done_seen", 64'(done_count - d0), 64'd1);
    check("ab_outputs_quiet",  64'(quiet),           64'd1);

    // Requester 3: 9 / 3 after the abort
    bus.i_req_dividend[3] = 16'd9;
    bus.i_req_divisor[3]  = 16'd3;
    bus.i_req_valid       = 4'b1000;
    #1;
    check("post_ready", 64'(bus.o_req_ready), 64'h8);
    wait_rsp(40, starts);
    bus.i_req_valid = 4'b0000;
    check("post_starts", 64'(starts),              64'd1);
    check("post_id",     64'(bus.o_rsp_id),        64'd3);
    check("post_q",      64'(bus.o_rsp_quotient),  64'd3);
    check("post_r",      64'(bus.o_rsp_remainder), 64'd0);
    check("post_dbz",    64'(bus.o_rsp_dbz),       64'd0);
    bus.i_rsp_ready = 1'b1;
    tick();
    bus.i_rsp_ready = 1'b0;
    check("post_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
